// File: rtl/cache_meta_ctrl_pkg.sv
// Shared types, field positions and helpers for the 2-way cache metadata controller.
package cache_meta_ctrl_pkg;

    // Address split: tag=[15:10], set=[9:4], offset=[3:0]
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned TAG_W    = 6;
    localparam int unsigned SET_W    = 6;
    localparam int unsigned NUM_SETS = 64;
    localparam int unsigned TAG_LSB  = 10;
    localparam int unsigned SET_LSB  = 4;

    // Line fill: eight 2-byte chunks per 16-byte line
    localparam int unsigned CHUNKS  = 8;
    localparam int unsigned CHUNK_W = 3;

    // Metadata byte layout {valid, lru, tag[5:0]}
    localparam int unsigned META_W      = 8;
    localparam int unsigned META_VALID  = 7;
    localparam int unsigned META_LRU    = 6;
    localparam int unsigned META_TAG_HI = 5;
    localparam int unsigned META_TAG_LO = 0;

    // Controller states
    typedef logic [2:0] state_t;
    localparam state_t StIdle      = 3'd0;
    localparam state_t StLookup    = 3'd1;
    localparam state_t StHitUpd    = 3'd2;
    localparam state_t StHitOther  = 3'd3;
    localparam state_t StFill      = 3'd4;
    localparam state_t StMetaVict  = 3'd5;
    localparam state_t StMetaOther = 3'd6;

    function automatic logic [META_W-1:0] make_meta(input logic valid, input logic lru,
                                                    input logic [TAG_W-1:0] tag);
        return {valid, lru, tag};
    endfunction

    // lru=1 marks the way that should be evicted next
    function automatic logic [META_W-1:0] set_lru(input logic [META_W-1:0] meta);
        logic [META_W-1:0] r;
        r = meta;
        r[META_LRU] = 1'b1;
        return r;
    endfunction

    // Victim priority: invalid way 0, invalid way 1, way with lru=1, else way 0
    function automatic logic pick_victim(input logic [META_W-1:0] d0,
                                         input logic [META_W-1:0] d1);
        logic v;
        if (!d0[META_VALID]) begin
            v = 1'b0;
        end else if (!d1[META_VALID]) begin
            v = 1'b1;
        end else if (d0[META_LRU]) begin
            v = 1'b0;
        end else if (d1[META_LRU]) begin
            v = 1'b1;
        end else begin
            v = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/onehot_dec6.sv
// 6-to-64 one-hot decoder with enable; drives the metadata set select.
module onehot_dec6 (
    input  logic        en,
    input  logic [5:0]  sel,
    output logic [63:0] onehot
);

    // Single bit at the selected position, all-zero when disabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_meta_ctrl.sv
// Two-way set-associative cache metadata controller: tag lookup, LRU update on hit,
// and an 8-chunk line fill with victim/non-victim metadata update on miss.
module cache_meta_ctrl
    import cache_meta_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                req_ready,
    output logic                done,
    output logic                hit,
    output logic [NUM_SETS-1:0] meta_block_en,
    output logic [META_W-1:0]   meta_din,
    output logic                meta_write0,
    output logic                meta_write1,
    input  logic [META_W-1:0]   meta_dout0,
    input  logic [META_W-1:0]   meta_dout1,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_data_valid,
    output logic                data_write,
    output logic                data_way,
    output logic [CHUNK_W-1:0]  data_word
);

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [META_W-1:0]  dout0_q, dout0_d;
    logic [META_W-1:0]  dout1_q, dout1_d;
    logic               hit_way_q, hit_way_d;
    logic               victim_q, victim_d;
    // Issue counter runs 0..8; bit CHUNK_W set means all chunks requested
    logic [CHUNK_W:0]   issue_cnt_q, issue_cnt_d;
    logic [CHUNK_W-1:0] ret_cnt_q, ret_cnt_d;
    logic               done_q, done_d;
    logic               hit_q, hit_d;

    logic               hit0, hit1;
    logic               in_idle;
    logic [META_W-1:0]  other_meta;

    // Byte offset is irrelevant to metadata and line fills
    logic unused_offset;
    assign unused_offset = ^req_addr[SET_LSB-1:0];

    assign in_idle = (state_q == StIdle);

    onehot_dec6 u_set_dec (
        .en     (!in_idle),
        .sel    (set_q),
        .onehot (meta_block_en)
    );

    // Tag compare against the live metadata read during LOOKUP
    always_comb begin
        hit0 = meta_dout0[META_VALID] && (meta_dout0[META_TAG_HI:META_TAG_LO] == tag_q);
        hit1 = meta_dout1[META_VALID] && (meta_dout1[META_TAG_HI:META_TAG_LO] == tag_q);
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        set_d       = set_q;
        dout0_d     = dout0_q;
        dout1_d     = dout1_q;
        hit_way_d   = hit_way_q;
        victim_d    = victim_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        done_d      = 1'b0;
        hit_d       = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    tag_d   = req_addr[ADDR_W-1:TAG_LSB];
                    set_d   = req_addr[TAG_LSB-1:SET_LSB];
                    state_d = StLookup;
                end
            end
            StLookup: begin
                dout0_d = meta_dout0;
                dout1_d = meta_dout1;
                if (hit0 || hit1) begin
                    // Way 0 wins when both ways match
                    hit_way_d = !hit0;
                    state_d   = StHitUpd;
                end else begin
                    victim_d    = pick_victim(meta_dout0, meta_dout1);
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = StFill;
                end
            end
            StHitUpd: begin
                state_d = StHitOther;
            end
            StHitOther: begin
                done_d  = 1'b1;
                hit_d   = 1'b1;
                state_d = StIdle;
            end
            StFill: begin
                if (!issue_cnt_q[CHUNK_W]) begin
                    issue_cnt_d = issue_cnt_q + 4'd1;
                end
                if (mem_data_valid) begin
                    ret_cnt_d = ret_cnt_q + 3'd1;
                    if (ret_cnt_q == 3'(CHUNKS - 1)) begin
                        state_d = StMetaVict;
                    end
                end
            end
            StMetaVict: begin
                state_d = StMetaOther;
            end
            StMetaOther: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Metadata write port: one way per cycle, only in the four update states
    always_comb begin
        meta_din    = '0;
        meta_write0 = 1'b0;
        meta_write1 = 1'b0;
        other_meta  = victim_q ? dout0_q : dout1_q;
        case (state_q)
            StHitUpd: begin
                meta_din    = make_meta(1'b1, 1'b0, tag_q);
                meta_write0 = !hit_way_q;
                meta_write1 = hit_way_q;
            end
            StHitOther: begin
                meta_din    = set_lru(hit_way_q ? dout0_q : dout1_q);
                meta_write0 = hit_way_q;
                meta_write1 = !hit_way_q;
            end
            StMetaVict: begin
                meta_din    = make_meta(1'b1, 1'b0, tag_q);
                meta_write0 = !victim_q;
                meta_write1 = victim_q;
            end
            StMetaOther: begin
                // An invalid non-victim keeps its byte untouched
                meta_din    = other_meta[META_VALID] ? set_lru(other_meta) : other_meta;
                meta_write0 = victim_q;
                meta_write1 = !victim_q;
            end
            default: begin
            end
        endcase
    end

    // Handshake, memory request and data-array fill outputs
    always_comb begin
        req_ready  = in_idle;
        done       = done_q;
        hit        = hit_q;
        mem_req    = (state_q == StFill) && !issue_cnt_q[CHUNK_W];
        mem_addr   = mem_req ? {tag_q, set_q, issue_cnt_q[CHUNK_W-1:0], 1'b0} : '0;
        data_write = (state_q == StFill) && mem_data_valid;
        data_way   = data_write ? victim_q : 1'b0;
        data_word  = data_write ? ret_cnt_q : '0;
    end

    // State and captured registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tag_q       <= '0;
            set_q       <= '0;
            dout0_q     <= '0;
            dout1_q     <= '0;
            hit_way_q   <= 1'b0;
            victim_q    <= 1'b0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            set_q       <= set_d;
            dout0_q     <= dout0_d;
            dout1_q     <= dout1_d;
            hit_way_q   <= hit_way_d;
            victim_q    <= victim_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
        end
    end

endmodule

// File: tb/tb_cache_meta_ctrl.sv
// Self-checking bench for cache_meta_ctrl: metadata array and memory models,
// table-driven request vectors, and a mid-fill reset sequence.
module tb_cache_meta_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic        req_ready, done, hit;
    logic [63:0] meta_block_en;
    logic [7:0]  meta_din;
    logic        meta_write0, meta_write1;
    logic [7:0]  meta_dout0, meta_dout1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_data_valid = 1'b0;
    logic        data_write, data_way;
    logic [2:0]  data_word;

    always #5 clk = ~clk;

    cache_meta_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .done           (done),
        .hit            (hit),
        .meta_block_en  (meta_block_en),
        .meta_din       (meta_din),
        .meta_write0    (meta_write0),
        .meta_write1    (meta_write1),
        .meta_dout0     (meta_dout0),
        .meta_dout1     (meta_dout1),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .data_write     (data_write),
        .data_way       (data_way),
        .data_word      (data_word)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  p0;
        logic [7:0]  p1;
        int          dly;
        bit          hold;
        bit          exp_hit;
        bit          vict;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;

    logic [7:0]  arr0 [64];
    logic [7:0]  arr1 [64];
    logic [15:0] exp_addr [$];
    logic [3:0]  exp_dw [$];
    int          pend [$];
    int          ret_delay = 1;
    int          cyc = 0;
    int          mw_cnt = 0;
    logic [5:0]  cur_set = 6'd0;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int en_idx(input logic [63:0] en);
        int r;
        r = 0;
        for (int i = 0; i < 64; i++) if (en[i]) r = i;
        return r;
    endfunction

    assign meta_dout0 = (meta_block_en != 64'd0) ? arr0[en_idx(meta_block_en)] : 8'h00;
    assign meta_dout1 = (meta_block_en != 64'd0) ? arr1[en_idx(meta_block_en)] : 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: each request returns ret_delay cycles later, in order
    task automatic responder();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_data_valid = 1'b0;
            if (pend.size() > 0 && pend[0] <= cyc) begin
                void'(pend.pop_front());
                mem_data_valid = 1'b1;
            end
            if (mem_req === 1'b1) pend.push_back(cyc + ret_delay);
        end
    endtask

    // Scoreboard pops and metadata array writes
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (exp_addr.size() == 0) check("mem_req_unexpected", mem_req, 64'd0);
                else check("mem_addr", mem_addr, exp_addr.pop_front());
            end
            if (data_write === 1'b1) begin
                if (exp_dw.size() == 0) check("data_write_unexpected", data_write, 64'd0);
                else check("data_way_word", {data_way, data_word}, exp_dw.pop_front());
            end
            if (meta_write0 === 1'b1 || meta_write1 === 1'b1) begin
                mw_cnt++;
                check("wr_exclusive", meta_write0 & meta_write1, 64'd0);
                check("blk_en_write", meta_block_en, 64'd1 << cur_set);
                if (meta_write0) arr0[en_idx(meta_block_en)] = meta_din;
                else arr1[en_idx(meta_block_en)] = meta_din;
            end
            if (req_ready === 1'b1) check("blk_en_idle", meta_block_en, 64'd0);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        cur_set = v.addr[9:4];
        arr0[cur_set] = v.p0;
        arr1[cur_set] = v.p1;
        ret_delay = v.dly;
        if (!v.exp_hit) begin
            for (int k = 0; k < 8; k++) begin
                exp_addr.push_back({v.addr[15:4], 3'(k), 1'b0});
                exp_dw.push_back({v.vict, 3'(k)});
            end
        end
        check($sformatf("v%0d_ready", idx), req_ready, 64'd1);
        req_addr = v.addr;
        req_valid = 1'b1;
        @(negedge clk);
        n = 1;
        if (v.hold) req_addr = 16'h0F00;
        else req_valid = 1'b0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        check($sformatf("v%0d_done", idx), done, 64'd1);
        check($sformatf("v%0d_hit", idx), hit, 64'(v.exp_hit));
        if (v.exp_hit) check($sformatf("v%0d_hit_latency", idx), 64'(n), 64'd4);
        check($sformatf("v%0d_way0", idx), arr0[cur_set], 64'(v.e0));
        check($sformatf("v%0d_way1", idx), arr1[cur_set], 64'(v.e1));
        n = 0;
        while (pend.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check($sformatf("v%0d_addr_left", idx), 64'(exp_addr.size()), 64'd0);
        check($sformatf("v%0d_words_left", idx), 64'(exp_dw.size()), 64'd0);
    endtask

    initial begin
        vec_t tbl [10];
        int   n;
        int   dwc;
        int   mw0;

        //          addr      p0     p1     dly hold  hit   vict  e0     e1
        tbl[0] = '{16'h1230, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h84, 8'h00};
        tbl[1] = '{16'h1230, 8'h84, 8'h00, 1, 1'b0, 1'b1, 1'b0, 8'h84, 8'h40};
        tbl[2] = '{16'h1A30, 8'h84, 8'hC5, 1, 1'b0, 1'b0, 1'b1, 8'hC4, 8'h86};
        tbl[3] = '{16'h1A30, 8'h81, 8'h82, 4, 1'b0, 1'b0, 1'b0, 8'h86, 8'hC2};
        tbl[4] = '{16'h1A30, 8'h05, 8'h86, 1, 1'b0, 1'b1, 1'b1, 8'h45, 8'h86};
        tbl[5] = '{16'h1A30, 8'h81, 8'h02, 2, 1'b0, 1'b0, 1'b1, 8'hC1, 8'h86};
        tbl[6] = '{16'h1A30, 8'h86, 8'h86, 1, 1'b0, 1'b1, 1'b0, 8'h86, 8'hC6};
        tbl[7] = '{16'h1A30, 8'hC1, 8'h82, 3, 1'b1, 1'b0, 1'b0, 8'h86, 8'hC2};
        tbl[8] = '{16'hFFF0, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'hBF, 8'h00};
        tbl[9] = '{16'h0000, 8'h00, 8'h00, 2, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00};

        for (int i = 0; i < 64; i++) begin
            arr0[i] = 8'h00;
            arr1[i] = 8'h00;
        end
        fork
            responder();
            monitor();
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 64'd1);
        check("rst_done", done, 64'd0);
        check("rst_hit", hit, 64'd0);
        check("rst_blk_en", meta_block_en, 64'd0);
        check("rst_meta_din", meta_din, 64'd0);
        check("rst_write0", meta_write0, 64'd0);
        check("rst_write1", meta_write1, 64'd0);
        check("rst_mem_req", mem_req, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_data_write", data_write, 64'd0);
        check("rst_data_way", data_way, 64'd0);
        check("rst_data_word", data_word, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // Reset after the third fill return: fill abandoned, no metadata writes
        cur_set = 6'h23;
        arr0[cur_set] = 8'h84;
        arr1[cur_set] = 8'hC5;
        ret_delay = 2;
        for (int k = 0; k < 8; k++) begin
            exp_addr.push_back({12'h1A3, 3'(k), 1'b0});
            exp_dw.push_back({1'b1, 3'(k)});
        end
        check("mr_ready", req_ready, 64'd1);
        req_addr = 16'h1A30;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        dwc = 0;
        n = 0;
        while (dwc < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (data_write === 1'b1) dwc++;
        end
        check("mr_returns_seen", 64'(dwc), 64'd3);
        mw0 = mw_cnt;
        rst_n = 1'b0;
        #1;
        exp_addr.delete();
        exp_dw.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check("mr_idle_ready", req_ready, 64'd1);
        check("mr_idle_mem_req", mem_req, 64'd0);
        check("mr_idle_blk_en", meta_block_en, 64'd0);
        n = 0;
        while (pend.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("mr_no_meta_writes", 64'(mw_cnt - mw0), 64'd0);
        check("mr_way0_kept", arr0[6'h23], 64'h84);
        check("mr_way1_kept", arr1[6'h23], 64'hC5);
        check("mr_still_idle", req_ready, 64'd1);

        // Fresh fill after the abandoned one must restart counts at word 0
        run_vec(tbl[2], 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
